ctrl_debouncer: RTL
===================

CTRL_DEBOUNCER -- requirements
Module: ctrl_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable clk samples needed to accept a press or release (legal range 2..65535).
REQ-002 SHALL have parameter TOGGLE_MODE, default 1, where 1 means ctrl toggles on each accepted press and 0 means ctrl follows the debounced button level.
REQ-003 SHALL have parameter CTRL_INIT, default 1'b1, the reset value of ctrl.
REQ-004 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous and active-low (rst=0 resets immediately, independent of clk).
REQ-006 SHALL have port: btn_in  input  1  raw asynchronous push-button, active-high, may bounce.
REQ-007 SHALL have port: ctrl  output  1  conditioned control level that drives the downstream counter's ctrl input.
REQ-008 SHALL have port: ctrl_pulse  output  1  single-cycle strobe on each accepted press.
REQ-009 SHALL have port: btn_level  output  1  debounced button level.

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer; only the second flop (sync) feeds the logic.
REQ-011 SHALL implement the FSM states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a stability counter cnt of width clog2(DEBOUNCE_CYCLES).
REQ-012 In IDLE, sync=1 SHALL move the FSM to PRESS_WAIT with cnt=0; sync=0 SHALL keep it in IDLE.
REQ-013 In PRESS_WAIT, sync=0 SHALL return the FSM to IDLE with cnt=0 and no output change.
REQ-014 In PRESS_WAIT, sync=1 with cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt.
REQ-015 In PRESS_WAIT, sync=1 with cnt=DEBOUNCE_CYCLES-1 SHALL move the FSM to HELD with cnt=0.
REQ-016 In HELD, sync=0 SHALL move the FSM to RELEASE_WAIT with cnt=0; sync=1 SHALL keep it in HELD.
REQ-017 In RELEASE_WAIT, sync=1 SHALL return the FSM to HELD with cnt=0 and no pulse.
REQ-018 In RELEASE_WAIT, sync=0 with cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt.
REQ-019 In RELEASE_WAIT, sync=0 with cnt=DEBOUNCE_CYCLES-1 SHALL move the FSM to IDLE.
REQ-020 ctrl_pulse SHALL be registered and high for exactly the first clock cycle after the PRESS_WAIT->HELD transition, and low at all other times.
REQ-021 btn_level SHALL be registered, 1 while the FSM is in HELD or RELEASE_WAIT, and 0 while it is in IDLE or PRESS_WAIT.
REQ-022 With TOGGLE_MODE=1, ctrl SHALL invert on the same edge that asserts ctrl_pulse and hold its value otherwise.
REQ-023 With TOGGLE_MODE=0, ctrl SHALL equal btn_level.
REQ-024 Latency SHALL be as follows: if btn_in is high and stable from sampling edge N, ctrl_pulse is high during the cycle after edge N+DEBOUNCE_CYCLES+2; release has the same latency to btn_level=0.
REQ-025 Any bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no output change, and a held button SHALL produce exactly one pulse regardless of hold time.
REQ-026 cnt SHALL never wrap, and SHALL be cleared on every state transition.

Reset
REQ-027 When rst=0, the block SHALL immediately force both sync flops to 0, state=IDLE, cnt=0, ctrl_pulse=0, btn_level=0 and ctrl=CTRL_INIT.
REQ-028 Reset asserted mid-PRESS_WAIT or mid-HELD SHALL discard progress, with no pulse on or after reset release.
REQ-029 After rst rises, the block SHALL treat a btn_in that is already high as a new press and require the full DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4, CTRL_INIT=1)
REQ-030 Reset: with rst=0 asserted between clk edges -> ctrl=1, ctrl_pulse=0 and btn_level=0 before the next edge.
REQ-031 Clean press: btn_in 0->1 held 20 cycles, TOGGLE_MODE=1 -> one ctrl_pulse 6 cycles after the first sampling edge, and ctrl 1->0 on the same edge.
REQ-032 Bounce rejection: btn_in pattern 1,0,1,1,0,1 (one cycle each), then 0 -> ctrl_pulse never asserts and ctrl stays 1.
REQ-033 Release glitch: while HELD, btn_in=0 for 2 cycles then 1 -> btn_level stays 1 and no second pulse occurs.
REQ-034 Two full presses, each held 10 cycles with 10 cycles released between them -> two pulses and ctrl sequence 1->0->1; with TOGGLE_MODE=0, ctrl follows btn_level.
REQ-035 Reset mid-press: rst=0 when cnt=2 in PRESS_WAIT with btn_in held high, rst=1 three cycles later -> no pulse until 6 cycles after reset release.

Source files
------------

// File: rtl/ctrl_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, press/release debounce FSM,
// and a registered control level that either toggles per press or follows the button.
module ctrl_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TOGGLE_MODE     = 1,
  parameter logic        CTRL_INIT       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic ctrl,
  output logic ctrl_pulse,
  output logic btn_level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit TOGGLE = (TOGGLE_MODE != 0);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             meta;
  logic             sync;

  // Synchronizer stage: only sync is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn_in;
      sync <= meta;
    end
  end

  // Debounce FSM stage: outputs are updated on the transition edge itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ctrl_pulse <= 1'b0;
      btn_level  <= 1'b0;
      ctrl       <= CTRL_INIT;
    end else begin
      ctrl_pulse <= 1'b0;
      // Level mode: ctrl tracks btn_level; transitions below override with the new level.
      if (!TOGGLE) ctrl <= btn_level;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sync) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= HELD;
            cnt        <= '0;
            ctrl_pulse <= 1'b1;
            btn_level  <= 1'b1;
            ctrl       <= TOGGLE ? ~ctrl : 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          cnt <= '0;
          if (!sync) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (sync) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            if (!TOGGLE) ctrl <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
